// File: rtl/ib_bridge_pkg.sv
// Shared types and helpers for the IB bridge controller: FSM state encodings and
// the timeout-counter width calculation.
package ib_bridge_pkg;

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_OFFER   = 2'd1,
    T_RELEASE = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_PUSH    = 2'd1,
    R_RELEASE = 2'd2
  } rx_state_e;

  // Bits needed to count 0..cycles-1; never narrower than one bit.
  function automatic int timer_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/ib_byte_fifo.sv
// Small synchronous byte FIFO; pointers carry an extra wrap bit so full and
// empty are distinguishable without a separate count.
module ib_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync2 #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_q <= RESET_VALUE;
      q_o    <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/ib_bridge_ctrl.sv
// Byte bridge between the host UART and the IB port-expander handshake: a FIFO-fed
// 4-phase TX offer path and a capture-and-forward RX path, each with a timeout.
module ib_bridge_ctrl
  import ib_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_valid,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_valid,
  input  logic       uart_tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_data_available,
  input  logic       tx_data_ack_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_available,
  output logic       tx_ack,
  output logic       overflow_err,
  output logic       timeout_err,
  input  logic       clr_err
);

  localparam int TIMER_W = timer_w(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

  logic ack_n_s;
  logic avail_s;

  sync2 #(.RESET_VALUE(1'b1)) u_sync_ack (
    .clk (clk), .nrst(nrst), .d_i(tx_data_ack_n), .q_o(ack_n_s)
  );

  sync2 #(.RESET_VALUE(1'b0)) u_sync_avail (
    .clk (clk), .nrst(nrst), .d_i(rx_data_available), .q_o(avail_s)
  );

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       fifo_push;
  logic       fifo_pop;

  // A pop in the same cycle frees a slot, so a push against a full FIFO still lands.
  assign fifo_push = uart_rx_valid && (!fifo_full || fifo_pop);

  ib_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .nrst   (nrst),
    .push_i (fifo_push),
    .data_i (uart_rx_data),
    .pop_i  (fifo_pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

  tx_state_e          tx_state_q, tx_state_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_avail_q, tx_avail_d;
  logic [TIMER_W-1:0] tx_timer_q, tx_timer_d;
  logic               tx_timeout;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_avail_d = tx_avail_q;
    tx_timer_d = '0;
    tx_timeout = 1'b0;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!fifo_empty && ack_n_s) begin
          tx_data_d  = fifo_head;
          tx_avail_d = 1'b1;
          fifo_pop   = 1'b1;
          tx_state_d = T_OFFER;
        end
      end
      T_OFFER: begin
        if (!ack_n_s) begin
          tx_avail_d = 1'b0;
          tx_state_d = T_RELEASE;
        end else if (tx_timer_q == TIMER_MAX) begin
          tx_avail_d = 1'b0;
          tx_timeout = 1'b1;
          tx_state_d = T_IDLE;
        end else begin
          tx_timer_d = tx_timer_q + TIMER_ONE;
        end
      end
      T_RELEASE: begin
        if (ack_n_s) begin
          tx_state_d = T_IDLE;
        end else if (tx_timer_q == TIMER_MAX) begin
          tx_timeout = 1'b1;
          tx_state_d = T_IDLE;
        end else begin
          tx_timer_d = tx_timer_q + TIMER_ONE;
        end
      end
      default: begin
        tx_avail_d = 1'b0;
        tx_state_d = T_IDLE;
      end
    endcase
  end

  rx_state_e          rx_state_q, rx_state_d;
  logic [7:0]         utx_data_q, utx_data_d;
  logic               utx_valid_q, utx_valid_d;
  logic               tx_ack_q, tx_ack_d;
  logic [TIMER_W-1:0] rx_timer_q, rx_timer_d;
  logic               rx_timeout;

  always_comb begin
    rx_state_d  = rx_state_q;
    utx_data_d  = utx_data_q;
    utx_valid_d = utx_valid_q;
    tx_ack_d    = tx_ack_q;
    rx_timer_d  = '0;
    rx_timeout  = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (avail_s) begin
          utx_data_d  = rx_data;
          utx_valid_d = 1'b1;
          rx_state_d  = R_PUSH;
        end
      end
      R_PUSH: begin
        // Waiting on the host UART here is deliberately untimed.
        if (utx_valid_q && uart_tx_ready) begin
          utx_valid_d = 1'b0;
          tx_ack_d    = 1'b1;
          rx_state_d  = R_RELEASE;
        end
      end
      R_RELEASE: begin
        if (!avail_s) begin
          tx_ack_d   = 1'b0;
          rx_state_d = R_IDLE;
        end else if (rx_timer_q == TIMER_MAX) begin
          tx_ack_d   = 1'b0;
          rx_timeout = 1'b1;
          rx_state_d = R_IDLE;
        end else begin
          rx_timer_d = rx_timer_q + TIMER_ONE;
        end
      end
      default: begin
        utx_valid_d = 1'b0;
        tx_ack_d    = 1'b0;
        rx_state_d  = R_IDLE;
      end
    endcase
  end

  logic overflow_q, overflow_d;
  logic timeout_q, timeout_d;

  // Set events take priority over a coincident clear.
  always_comb begin
    overflow_d = clr_err ? 1'b0 : overflow_q;
    timeout_d  = clr_err ? 1'b0 : timeout_q;
    if (uart_rx_valid && !fifo_push) overflow_d = 1'b1;
    if (tx_timeout || rx_timeout)    timeout_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_state_q  <= T_IDLE;
      tx_data_q   <= '0;
      tx_avail_q  <= 1'b0;
      tx_timer_q  <= '0;
      rx_state_q  <= R_IDLE;
      utx_data_q  <= '0;
      utx_valid_q <= 1'b0;
      tx_ack_q    <= 1'b0;
      rx_timer_q  <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_data_q   <= tx_data_d;
      tx_avail_q  <= tx_avail_d;
      tx_timer_q  <= tx_timer_d;
      rx_state_q  <= rx_state_d;
      utx_data_q  <= utx_data_d;
      utx_valid_q <= utx_valid_d;
      tx_ack_q    <= tx_ack_d;
      rx_timer_q  <= rx_timer_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
    end
  end

  assign tx_data           = tx_data_q;
  assign tx_data_available = tx_avail_q;
  assign uart_tx_data      = utx_data_q;
  assign uart_tx_valid     = utx_valid_q;
  assign tx_ack            = tx_ack_q;
  assign overflow_err      = overflow_q;
  assign timeout_err       = timeout_q;

endmodule

// File: tb/tb_ib_bridge_ctrl.sv
// Directed self-checking bench for ib_bridge_ctrl with a short timeout and a
// concurrent scoreboarded TX/RX phase.
module tb_ib_bridge_ctrl;

  localparam int TO_CYC = 100;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] uart_rx_data = '0;
  logic       uart_rx_valid = 1'b0;
  logic [7:0] uart_tx_data;
  logic       uart_tx_valid;
  logic       uart_tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_data_available;
  logic       tx_data_ack_n = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_data_available = 1'b0;
  logic       tx_ack;
  logic       overflow_err;
  logic       timeout_err;
  logic       clr_err = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ib_bridge_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .uart_rx_data     (uart_rx_data),
    .uart_rx_valid    (uart_rx_valid),
    .uart_tx_data     (uart_tx_data),
    .uart_tx_valid    (uart_tx_valid),
    .uart_tx_ready    (uart_tx_ready),
    .tx_data          (tx_data),
    .tx_data_available(tx_data_available),
    .tx_data_ack_n    (tx_data_ack_n),
    .rx_data          (rx_data),
    .rx_data_available(rx_data_available),
    .tx_ack           (tx_ack),
    .overflow_err     (overflow_err),
    .timeout_err      (timeout_err),
    .clr_err          (clr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic sig_val(input int sel);
    case (sel)
      0: return tx_data_available;
      1: return uart_tx_valid;
      2: return tx_ack;
      default: return timeout_err;
    endcase
  endfunction

  // Wait (sampling on falling edges) until the selected output reaches level;
  // the final value is itself a comparison, so an expired budget is reported.
  task automatic wait_sig(input int sel, input logic level, input int budget, input string tag);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sig_val(sel) == level) break;
    end
    check(tag, {31'd0, sig_val(sel)}, {31'd0, level});
  endtask

  task automatic push_byte(input logic [7:0] b);
    uart_rx_data  = b;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic meter_take(input logic [7:0] exp, input string tag);
    wait_sig(0, 1'b1, 60, {tag, "_offer"});
    check({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp});
    tx_data_ack_n = 1'b0;
    wait_sig(0, 1'b0, 8, {tag, "_drop"});
    tx_data_ack_n = 1'b1;
  endtask

  function automatic logic [31:0] all_outs();
    return {11'd0, uart_tx_data, uart_tx_valid, tx_data, tx_data_available,
            tx_ack, overflow_err, timeout_err};
  endfunction

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int tx_pushed, tx_got, rx_got;

  initial begin
    // Reset state
    idle(2);
    check("reset_outputs", all_outs(), 32'd0);
    nrst = 1'b1;
    idle(3);
    check("post_reset_outputs", all_outs(), 32'd0);

    // 1: single byte through the 4-phase handshake
    push_byte(8'hA5);
    wait_sig(0, 1'b1, 4, "t1_avail_within4");
    check("t1_tx_data", {24'd0, tx_data}, 32'hA5);
    tx_data_ack_n = 1'b0;
    wait_sig(0, 1'b0, 6, "t1_avail_drop");
    check("t1_data_held", {24'd0, tx_data}, 32'hA5);
    tx_data_ack_n = 1'b1;
    idle(8);
    check("t1_back_idle", {31'd0, tx_data_available}, 32'd0);

    // 2: overflow with meter stalled (ack_n held low keeps TX idle)
    tx_data_ack_n = 1'b0;
    idle(4);
    for (int i = 1; i <= 6; i++) push_byte(8'(i));
    check("t2_overflow_set", {31'd0, overflow_err}, 32'd1);
    check("t2_no_offer", {31'd0, tx_data_available}, 32'd0);
    tx_data_ack_n = 1'b1;
    for (int i = 1; i <= 4; i++) meter_take(8'(i), $sformatf("t2_b%0d", i));
    idle(10);
    check("t2_fifo_drained", {31'd0, tx_data_available}, 32'd0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t2_overflow_clr", {31'd0, overflow_err}, 32'd0);

    // 3: meter->host with host back-pressure
    rx_data = 8'h3C;
    rx_data_available = 1'b1;
    wait_sig(1, 1'b1, 6, "t3_valid");
    rx_data = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_hold%0d", i), {22'd0, uart_tx_valid, uart_tx_data, tx_ack},
            {22'd0, 1'b1, 8'h3C, 1'b0});
      @(negedge clk);
    end
    uart_tx_ready = 1'b1;
    wait_sig(2, 1'b1, 3, "t3_ack_rise");
    uart_tx_ready = 1'b0;
    check("t3_valid_drop", {31'd0, uart_tx_valid}, 32'd0);
    idle(5);
    check("t3_ack_held", {31'd0, tx_ack}, 32'd1);
    rx_data_available = 1'b0;
    wait_sig(2, 1'b0, 6, "t3_ack_fall");
    idle(5);
    check("t3_no_recapture", {31'd0, uart_tx_valid}, 32'd0);

    // 4: TX timeout, then the next queued byte is offered
    push_byte(8'h11);
    push_byte(8'h22);
    wait_sig(3, 1'b1, TO_CYC + 20, "t4_timeout_err");
    check("t4_avail_dropped", {31'd0, tx_data_available}, 32'd0);
    meter_take(8'h22, "t4_next");
    idle(6);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t4_timeout_clr", {31'd0, timeout_err}, 32'd0);

    // 5: concurrent TX and RX with random delays
    tx_pushed = 0; tx_got = 0; rx_got = 0;
    fork
      begin : host_tx
        for (int i = 0; i < 8; i++) begin
          while (tx_pushed - tx_got >= 3) @(negedge clk);
          tx_exp.push_back(8'(8'h40 + i * 7));
          tx_pushed++;
          push_byte(8'(8'h40 + i * 7));
          idle($urandom_range(0, 10));
        end
      end
      begin : meter_tx
        for (int i = 0; i < 8; i++) begin
          logic [7:0] want;
          wait_sig(0, 1'b1, 400, $sformatf("t5_tx_offer%0d", i));
          want = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'h00;
          check($sformatf("t5_tx_byte%0d", i), {24'd0, tx_data}, {24'd0, want});
          tx_got++;
          idle($urandom_range(0, 50));
          tx_data_ack_n = 1'b0;
          wait_sig(0, 1'b0, 8, $sformatf("t5_tx_drop%0d", i));
          idle($urandom_range(0, 50));
          tx_data_ack_n = 1'b1;
        end
      end
      begin : meter_rx
        for (int i = 0; i < 8; i++) begin
          rx_exp.push_back(8'(8'h90 + i * 3));
          rx_data = 8'(8'h90 + i * 3);
          rx_data_available = 1'b1;
          wait_sig(2, 1'b1, 300, $sformatf("t5_rx_ack%0d", i));
          idle($urandom_range(0, 50));
          rx_data_available = 1'b0;
          wait_sig(2, 1'b0, 8, $sformatf("t5_rx_unack%0d", i));
          idle($urandom_range(0, 20));
        end
      end
      begin : host_rx
        for (int i = 0; i < 8; i++) begin
          logic [7:0] want;
          wait_sig(1, 1'b1, 300, $sformatf("t5_rx_valid%0d", i));
          want = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'h00;
          check($sformatf("t5_rx_byte%0d", i), {24'd0, uart_tx_data}, {24'd0, want});
          rx_got++;
          idle($urandom_range(0, 50));
          uart_tx_ready = 1'b1;
          @(negedge clk);
          uart_tx_ready = 1'b0;
        end
      end
    join
    idle(10);
    check("t5_counts", {16'(tx_got), 16'(rx_got)}, {16'd8, 16'd8});
    check("t5_no_extra", {31'd0, tx_data_available | uart_tx_valid}, 32'd0);
    check("t5_no_errors", {30'd0, overflow_err, timeout_err}, 32'd0);

    // 6: asynchronous reset mid-transfer
    push_byte(8'h5A);
    wait_sig(0, 1'b1, 6, "t6_in_offer");
    rx_data = 8'h77;
    rx_data_available = 1'b1;
    uart_tx_ready = 1'b1;
    wait_sig(2, 1'b1, 10, "t6_in_release");
    uart_tx_ready = 1'b0;
    push_byte(8'h66);
    push_byte(8'h67);
    #2 nrst = 1'b0;
    #1 check("t6_async_drop", all_outs(), 32'd0);
    rx_data_available = 1'b0;
    idle(2);
    nrst = 1'b1;
    idle(10);
    check("t6_fifo_empty", {30'd0, tx_data_available, uart_tx_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "global time limit");
  end

endmodule
